// File: rtl/mna_flit_scheduler_if.sv
// Request and flit-link signal bundle for mna_flit_scheduler.
// The scheduler uses the slave modport; the requester/router side uses master.
interface mna_flit_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  vc_free;
  logic [7:0]  vc_claim;
  logic [33:0] flit_data;
  logic        flit_valid;
  logic        flit_ready;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, vc_free, flit_ready,
    output req_ready, vc_claim, flit_data, flit_valid, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, vc_free, flit_ready,
    input  req_ready, vc_claim, flit_data, flit_valid, busy
  );
endinterface

// File: rtl/mna_flit_scheduler.sv
// Master NA request sequencer: latches one request, claims a VC, emits 2/3-flit packet.
// Define MNA_VC_ROUND_ROBIN_EN for round-robin VC selection (default: lowest index wins).
module mna_flit_scheduler #(
  parameter logic [3:0] SRC_ADDR = 4'b0001
) (
  input logic                  clk,
  input logic                  rst_n,
  mna_flit_scheduler_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALLOC = 3'd1;
  localparam logic [2:0] HEAD  = 3'd2;
  localparam logic [2:0] BODY  = 3'd3;
  localparam logic [2:0] TAIL  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  vc_idx_q, vc_idx_d;
  logic [7:0]  vc_claim_q, vc_claim_d;

  logic        sel_found;
  logic [2:0]  sel_idx;

`ifdef MNA_VC_ROUND_ROBIN_EN
  logic [2:0] rr_ptr_q;
  logic [2:0] rr_cand;

  // Scan from the pointer upward; 3-bit addition gives the 7 -> 0 wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    rr_cand   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      rr_cand = rr_ptr_q + 3'(i);
      if (!sel_found && bus.vc_free[rr_cand]) begin
        sel_found = 1'b1;
        sel_idx   = rr_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 3'd0;
    end else if (state_q == ALLOC && sel_found) begin
      rr_ptr_q <= sel_idx + 3'd1;
    end
  end
`else
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.vc_free[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    vc_idx_d   = vc_idx_q;
    vc_claim_d = 8'd0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        if (sel_found) begin
          vc_idx_d   = sel_idx;
          vc_claim_d = 8'd1 << sel_idx;
          state_d    = HEAD;
        end
      end
      HEAD: begin
        if (bus.flit_ready) state_d = write_q ? BODY : TAIL;
      end
      BODY: begin
        if (bus.flit_ready) state_d = TAIL;
      end
      TAIL: begin
        if (bus.flit_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      vc_idx_q   <= 3'd0;
      vc_claim_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vc_idx_q   <= vc_idx_d;
      vc_claim_q <= vc_claim_d;
    end
  end

  // Flit outputs decode registered state only, so they stay stable under backpressure.
  always_comb begin
    bus.flit_valid = 1'b0;
    bus.flit_data  = 34'd0;
    case (state_q)
      HEAD: begin
        bus.flit_valid = 1'b1;
        bus.flit_data  = {2'b10, vc_idx_q, addr_q[31:28], SRC_ADDR, 20'd0, ~write_q};
      end
      BODY: begin
        bus.flit_valid = 1'b1;
        bus.flit_data  = {2'b00, addr_q};
      end
      TAIL: begin
        bus.flit_valid = 1'b1;
        bus.flit_data  = {2'b01, write_q ? wdata_q : addr_q};
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.vc_claim  = vc_claim_q;

endmodule

// File: tb/tb_mna_flit_scheduler.sv
// Bench for mna_flit_scheduler: queue-based packet model checked every cycle,
// directed scenarios with literal flit values, then randomized traffic.
module tb_mna_flit_scheduler;

  localparam logic [3:0] SRC = 4'b0001;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mna_flit_scheduler_if bus ();

  mna_flit_scheduler #(.SRC_ADDR(SRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a request is either waiting for a VC, or expanded into a queue of flits.
  bit          m_pend;
  logic [31:0] m_addr, m_wdata;
  bit          m_wr;
  logic [33:0] m_flits[$];
  logic [7:0]  m_claim;
  int          m_ptr;

  function automatic logic [33:0] header(int v, logic [31:0] a, bit wr);
    return {2'b10, 3'(v), a[31:28], SRC, 20'd0, ~wr};
  endfunction

  function automatic bit m_idle();
    return !m_pend && m_flits.size() == 0;
  endfunction

  function automatic int pick_vc(logic [7:0] free);
    int v = -1;
`ifdef MNA_VC_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) begin
      int j = (m_ptr + i) % 8;
      if (v < 0 && free[j]) v = j;
    end
`else
    for (int i = 0; i < 8; i++) if (v < 0 && free[i]) v = i;
`endif
    return v;
  endfunction

  // Applies the inputs seen at the last rising edge.
  task automatic model_step();
    logic [7:0] claim_next = 8'd0;
    if (!rst_n) begin
      m_pend = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_ptr = 0;
      m_flits.delete();
    end else if (m_idle()) begin
      if (bus.req_valid) begin
        m_pend = 1; m_wr = bus.req_write; m_addr = bus.req_addr; m_wdata = bus.req_wdata;
      end
    end else if (m_pend) begin
      if (bus.vc_free != 8'd0) begin
        int v = pick_vc(bus.vc_free);
        m_flits.push_back(header(v, m_addr, m_wr));
        if (m_wr) begin
          m_flits.push_back({2'b00, m_addr});
          m_flits.push_back({2'b01, m_wdata});
        end else begin
          m_flits.push_back({2'b01, m_addr});
        end
        claim_next = 8'd1 << v;
        m_ptr = (v + 1) % 8;
        m_pend = 0;
      end
    end else if (bus.flit_ready) begin
      void'(m_flits.pop_front());
    end
    m_claim = claim_next;
  endtask

  task automatic chk(string name, logic [33:0] act, logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit idle = m_idle();
    chk("req_ready", 34'(bus.req_ready), 34'(idle));
    chk("busy", 34'(bus.busy), 34'(!idle));
    chk("flit_valid", 34'(bus.flit_valid), 34'(m_flits.size() > 0));
    chk("flit_data", bus.flit_data, m_flits.size() > 0 ? m_flits[0] : 34'd0);
    chk("vc_claim", 34'(bus.vc_claim), 34'(m_claim));
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
  endtask

  task automatic send_req(bit wr, logic [31:0] a, logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if (bus.req_ready === 1'b1) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", max_cycles);
    end
  endtask

  logic [7:0] rr_exp[3];

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.vc_free = 8'd0; bus.flit_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 34'(bus.req_ready), 34'd1);
    chk("rst_flit_valid", 34'(bus.flit_valid), 34'd0);
    chk("rst_flit_data", bus.flit_data, 34'd0);
    chk("rst_vc_claim", 34'(bus.vc_claim), 34'd0);
    chk("rst_busy", 34'(bus.busy), 34'd0);
    rst_n = 1'b1;
    tick();

    // Write on VC2, dest 3, src 1.
    bus.vc_free = 8'b0000_0100; bus.flit_ready = 1'b1;
    send_req(1'b1, 32'h3000_0010, 32'hDEAD_BEEF);
    chk("wr_alloc_ready", 34'(bus.req_ready), 34'd0);
    tick();
    chk("wr_claim", 34'(bus.vc_claim), 34'h04);
    chk("wr_head", bus.flit_data, 34'h2_4620_0000);
    tick();
    chk("wr_claim_pulse", 34'(bus.vc_claim), 34'h00);
    chk("wr_body", bus.flit_data, 34'h0_3000_0010);
    tick();
    chk("wr_tail", bus.flit_data, 34'h1_DEAD_BEEF);
    tick();
    chk("wr_done_busy", 34'(bus.busy), 34'd0);
    chk("wr_done_ready", 34'(bus.req_ready), 34'd1);

    // Read on VC7.
    bus.vc_free = 8'h80;
    send_req(1'b0, 32'h5000_0004, 32'h1111_2222);
    tick();
    chk("rd_head", bus.flit_data, 34'h2_EA20_0001);
    tick();
    chk("rd_tail", bus.flit_data, 34'h1_5000_0004);
    tick();
    chk("rd_done_valid", 34'(bus.flit_valid), 34'd0);

    // Backpressure during BODY; a request offered meanwhile must be ignored.
    bus.vc_free = 8'h01;
    send_req(1'b1, 32'h1234_5678, 32'hCAFE_F00D);
    tick();
    tick();
    chk("bp_body", bus.flit_data, 34'h0_1234_5678);
    bus.flit_ready = 1'b0; bus.req_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_hold", bus.flit_data, 34'h0_1234_5678);
      chk("bp_valid", 34'(bus.flit_valid), 34'd1);
      chk("bp_ready", 34'(bus.req_ready), 34'd0);
    end
    bus.req_valid = 1'b0; bus.flit_ready = 1'b1;
    tick();
    chk("bp_tail", bus.flit_data, 34'h1_CAFE_F00D);
    wait_idle(4);

    // VC starvation then release with two free VCs.
    bus.vc_free = 8'h00;
    send_req(1'b0, 32'h2000_0000, 32'h0);
    repeat (10) begin
      tick();
      chk("stv_valid", 34'(bus.flit_valid), 34'd0);
      chk("stv_claim", 34'(bus.vc_claim), 34'd0);
      chk("stv_busy", 34'(bus.busy), 34'd1);
    end
    bus.vc_free = 8'h30;
    tick();
    chk("stv_claim_grant", 34'(bus.vc_claim), 34'h10);
    chk("stv_head", bus.flit_data, 34'h2_8420_0001);
    bus.vc_free = 8'h00;
    wait_idle(4);

    // Three packets with every VC free, from a freshly reset pointer.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`ifdef MNA_VC_ROUND_ROBIN_EN
    rr_exp[0] = 8'h01; rr_exp[1] = 8'h02; rr_exp[2] = 8'h04;
`else
    rr_exp[0] = 8'h01; rr_exp[1] = 8'h01; rr_exp[2] = 8'h01;
`endif
    bus.vc_free = 8'hFF; bus.flit_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_req(1'b1, 32'h4000_0000 + 32'(k), 32'h100 + 32'(k));
      tick();
      chk("rr_claim", 34'(bus.vc_claim), 34'(rr_exp[k]));
      wait_idle(6);
    end

    // Reset while the header is stalled.
    bus.vc_free = 8'h01; bus.flit_ready = 1'b0;
    send_req(1'b1, 32'h6000_0000, 32'h5555_AAAA);
    tick();
    chk("mid_head_valid", 34'(bus.flit_valid), 34'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 34'(bus.flit_valid), 34'd0);
    chk("mid_rst_ready", 34'(bus.req_ready), 34'd1);
    chk("mid_rst_data", bus.flit_data, 34'd0);
    rst_n = 1'b1; bus.flit_ready = 1'b1;
    send_req(1'b0, 32'h7000_0008, 32'h0);
    tick();
    chk("mid_new_head", bus.flit_data, 34'h2_0E20_0001);
    wait_idle(4);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      bus.vc_free    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      bus.flit_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
